// File: rtl/synthesijer_faddsub.sv
// Four-stage pipelined IEEE-754 add/subtract with flush-to-zero and round-to-nearest-even.
// Stages: unpack/order, align, add/LZC, normalise/round/pack into the output register.
module synthesijer_faddsub #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [EXP_W+MAN_W:0] a,
    input  logic [EXP_W+MAN_W:0] b,
    input  logic                 sub,
    input  logic                 nd,
    output logic [EXP_W+MAN_W:0] result,
    output logic                 valid,
    output logic [2:0]           flags
);
    localparam int W   = EXP_W + MAN_W + 1;
    localparam int AW  = MAN_W + 4;
    localparam int SW  = MAN_W + 5;
    localparam int LZW = $clog2(SW + 1);
    localparam int SHW = $clog2(MAN_W + 4);
    localparam int XW  = EXP_W + LZW + 1;
    localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    typedef struct packed {
        logic             nan, ainf, binf, azero, bzero, sa, sb, eff_sub, sx;
        logic [EXP_W-1:0] ex;
        logic [W-2:0]     amag, bmag;
    } ctl_t;

    function automatic logic [LZW-1:0] lzc(input logic [SW-1:0] v);
        lzc = LZW'(SW);
        for (int i = 0; i < SW; i++)
            if (v[i]) lzc = LZW'(SW - 1 - i);
    endfunction

    logic [3:0]       vld;
    ctl_t             c1, s1, s2, s3;
    logic [EXP_W-1:0] ea, eb, ey1, s1_ey, dexp;
    logic [W-2:0]     ka, kb;
    logic             a_zero, b_zero, b_sign, swap;
    logic [MAN_W:0]   mx1, my1, s1_mx, s1_my;

    // Denormals collapse to a zero key so they compare and align as zero.
    always_comb begin
        ea     = a[W-2:MAN_W];
        eb     = b[W-2:MAN_W];
        a_zero = (ea == '0);
        b_zero = (eb == '0);
        b_sign = b[W-1] ^ sub;
        ka     = a_zero ? '0 : a[W-2:0];
        kb     = b_zero ? '0 : b[W-2:0];
        swap   = (kb > ka);
        c1         = '0;
        c1.nan     = (&ea && |a[MAN_W-1:0]) || (&eb && |b[MAN_W-1:0]);
        c1.ainf    = &ea && (a[MAN_W-1:0] == '0);
        c1.binf    = &eb && (b[MAN_W-1:0] == '0);
        c1.azero   = a_zero;
        c1.bzero   = b_zero;
        c1.sa      = a[W-1];
        c1.sb      = b_sign;
        c1.eff_sub = a[W-1] ^ b_sign;
        c1.sx      = swap ? b_sign : a[W-1];
        c1.ex      = swap ? kb[W-2:MAN_W] : ka[W-2:MAN_W];
        c1.amag    = a[W-2:0];
        c1.bmag    = b[W-2:0];
        ey1        = swap ? ka[W-2:MAN_W] : kb[W-2:MAN_W];
        mx1        = swap ? {~b_zero, kb[MAN_W-1:0]} : {~a_zero, ka[MAN_W-1:0]};
        my1        = swap ? {~a_zero, ka[MAN_W-1:0]} : {~b_zero, kb[MAN_W-1:0]};
    end

    logic [SHW-1:0]             sh;
    logic [2*(MAN_W+3)-1:0]     wide;
    logic [AW-1:0]              ya, s2_x, s2_y;

    always_comb begin
        dexp = s1.ex - s1_ey;
        sh   = (32'(dexp) > MAN_W + 3) ? SHW'(MAN_W + 3) : SHW'(dexp);
        wide = {s1_my, 2'b00, {(MAN_W+3){1'b0}}} >> sh;
        ya   = {wide[2*(MAN_W+3)-1 -: MAN_W+3], |wide[MAN_W+2:0]};
    end

    logic [SW-1:0]  sum3, s3_sum;
    logic [LZW-1:0] s3_lz;

    always_comb begin
        sum3 = s2.eff_sub ? ({1'b0, s2_x} - {1'b0, s2_y}) : ({1'b0, s2_x} + {1'b0, s2_y});
    end

    always_ff @(posedge clk) begin
        s1     <= c1;
        s1_ey  <= ey1;
        s1_mx  <= mx1;
        s1_my  <= my1;
        s2     <= s1;
        s2_x   <= {s1_mx, 3'b000};
        s2_y   <= ya;
        s3     <= s2;
        s3_sum <= sum3;
        s3_lz  <= lzc(sum3);
    end

    logic [AW-1:0]    nrm;
    logic [XW-1:0]    e_n, e_r;
    logic             rnd_up, ofl, ufl;
    logic [MAN_W+1:0] mant_r;
    logic [MAN_W-1:0] frac;
    logic [W-1:0]     res4;
    logic [2:0]       flg4;

    always_comb begin
        if (s3_sum[SW-1]) begin
            nrm = {s3_sum[SW-1:2], |s3_sum[1:0]};
            e_n = XW'(s3.ex) + XW'(1);
        end else begin
            nrm = s3_sum[AW-1:0] << (s3_lz - LZW'(1));
            e_n = XW'(s3.ex) - XW'(s3_lz) + XW'(1);
        end
        rnd_up = nrm[2] & (nrm[3] | nrm[1] | nrm[0]);
        mant_r = {1'b0, nrm[AW-1:3]} + (MAN_W+2)'(rnd_up);
        e_r    = mant_r[MAN_W+1] ? e_n + XW'(1) : e_n;
        frac   = mant_r[MAN_W+1] ? mant_r[MAN_W:1] : mant_r[MAN_W-1:0];
        // e_r is two's complement: the top bit marks an exponent below the normal range.
        ofl    = !e_r[XW-1] && (e_r >= XW'((1 << EXP_W) - 1));
        ufl    = e_r[XW-1] || (e_r == '0);
        res4   = {s3.sx, e_r[EXP_W-1:0], frac};
        flg4   = 3'b000;
        if (s3.nan)
            res4 = QNAN;
        else if (s3.ainf && s3.binf && s3.eff_sub) begin
            res4 = QNAN;
            flg4 = 3'b100;
        end else if (s3.ainf)
            res4 = {s3.sa, s3.amag};
        else if (s3.binf)
            res4 = {s3.sb, s3.bmag};
        else if (s3.azero && s3.bzero)
            res4 = {s3.sa & s3.sb, {(W-1){1'b0}}};
        else if (s3.azero)
            res4 = {s3.sb, s3.bmag};
        else if (s3.bzero)
            res4 = {s3.sa, s3.amag};
        else if (s3_sum == '0)
            res4 = '0;
        else if (ofl) begin
            res4 = {s3.sx, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            flg4 = 3'b010;
        end else if (ufl) begin
            res4 = {s3.sx, {(W-1){1'b0}}};
            flg4 = 3'b001;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld    <= '0;
            result <= '0;
            flags  <= '0;
        end else begin
            vld <= {vld[2:0], nd};
            if (vld[2]) begin
                result <= res4;
                flags  <= flg4;
            end
        end
    end

    assign valid = vld[3];

endmodule

// File: tb/tb_synthesijer_faddsub.sv
// Bench for synthesijer_faddsub (single precision): directed cases, reset behaviour and
// random streams checked against a reference built on double-precision real arithmetic.
module tb_synthesijer_faddsub;
    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] a     = '0;
    logic [31:0] b     = '0;
    logic        sub   = 1'b0;
    logic        nd    = 1'b0;
    logic [31:0] result;
    logic        valid;
    logic [2:0]  flags;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [34:0] expq[$];

    localparam logic [31:0] QNAN = 32'h7FC00000;

    synthesijer_faddsub dut (
        .clk   (clk),
        .reset (reset),
        .a     (a),
        .b     (b),
        .sub   (sub),
        .nd    (nd),
        .result(result),
        .valid (valid),
        .flags (flags)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic real to_real(input logic [31:0] x);
        logic [10:0] de;
        de = 11'(x[30:23]) + 11'd896;
        return $bitstoreal({x[31], de, x[22:0], 29'b0});
    endfunction

    // Round a double to single with RNE and an unbounded exponent, then apply overflow/flush.
    function automatic logic [34:0] round_single(input real r);
        logic [63:0] db;
        int          e;
        logic [24:0] m;
        logic        up;
        db = $realtobits(r);
        e  = int'(db[62:52]) - 896;
        up = db[28] & ((|db[27:0]) | db[29]);
        m  = {2'b01, db[51:29]} + 25'(up);
        if (m[24]) begin
            e = e + 1;
            m = m >> 1;
        end
        if (e >= 255) return {3'b010, db[63], 8'hFF, 23'h0};
        if (e <= 0)   return {3'b001, db[63], 31'h0};
        return {3'b000, db[63], 8'(e), m[22:0]};
    endfunction

    function automatic logic [34:0] ref_model(input logic [31:0] x, input logic [31:0] y,
                                              input logic s);
        logic [31:0] ys;
        logic        xn, yn, xi, yi, xz, yz;
        real         r;
        ys = {y[31] ^ s, y[30:0]};
        xn = (x[30:23] == 8'hFF) && (x[22:0] != 0);
        yn = (y[30:23] == 8'hFF) && (y[22:0] != 0);
        xi = (x[30:23] == 8'hFF) && (x[22:0] == 0);
        yi = (y[30:23] == 8'hFF) && (y[22:0] == 0);
        xz = (x[30:23] == 8'h00);
        yz = (y[30:23] == 8'h00);
        if (xn || yn) return {3'b000, QNAN};
        if (xi && yi && (x[31] != ys[31])) return {3'b100, QNAN};
        if (xi) return {3'b000, x};
        if (yi) return {3'b000, ys};
        if (xz && yz) return {3'b000, x[31] & ys[31], 31'h0};
        if (xz) return {3'b000, ys};
        if (yz) return {3'b000, x};
        r = to_real(x) + to_real(ys);
        if (r == 0.0) return 35'h0;
        return round_single(r);
    endfunction

    function automatic logic [31:0] rand_normal(input logic [7:0] near, input bit use_near);
        int t;
        if (use_near) begin
            t = int'(near) + int'($urandom_range(0, 6)) - 3;
            if (t < 1)   t = 1;
            if (t > 254) t = 254;
        end else begin
            t = int'($urandom_range(1, 254));
        end
        return {1'($urandom_range(0, 1)), 8'(t), 23'($urandom)};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks = n_checks + 1;
        assert (obs === expv) n_pass = n_pass + 1;
        else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    endtask

    task automatic run_op(input string tag, input logic [31:0] ai, input logic [31:0] bi,
                          input logic si, input logic [31:0] er, input logic [2:0] ef);
        a = ai; b = bi; sub = si; nd = 1'b1;
        @(posedge clk); #1;
        nd = 1'b0; a = $urandom; b = $urandom; sub = ~si;
        for (int k = 0; k < 3; k++) begin
            chk({tag, "_early"}, 64'(valid), 64'(0));
            @(posedge clk); #1;
        end
        chk({tag, "_valid"}, 64'(valid), 64'(1));
        chk({tag, "_res"}, 64'(result), 64'(er));
        chk({tag, "_flg"}, 64'(flags), 64'(ef));
        @(posedge clk); #1;
        chk({tag, "_one"}, 64'(valid), 64'(0));
        chk({tag, "_hold"}, 64'(result), 64'(er));
    endtask

    task automatic stream(input string tag, input int n);
        logic [31:0] x, y;
        logic [34:0] e;
        for (int k = 0; k < n + 4; k++) begin
            if (k < n) begin
                x = rand_normal(8'd0, 1'b0);
                y = rand_normal(x[30:23], $urandom_range(0, 3) != 0);
                if ($urandom_range(0, 7) == 0) y = {y[31], x[30:0]};
                a = x; b = y; sub = k[0]; nd = 1'b1;
                expq.push_back(ref_model(x, y, k[0]));
            end else begin
                nd = 1'b0;
            end
            @(posedge clk); #1;
            if (k >= 3 && k - 3 < n) begin
                e = expq.pop_front();
                chk({tag, "_valid"}, 64'(valid), 64'(1));
                chk({tag, "_res"}, 64'(result), 64'(e[31:0]));
                chk({tag, "_flg"}, 64'(flags), 64'(e[34:32]));
            end else begin
                chk({tag, "_idle"}, 64'(valid), 64'(0));
            end
        end
        nd = 1'b0;
    endtask

    initial begin
        #2 reset = 1'b0;
        a = 32'h40400000; b = 32'h3F800000; nd = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 64'(valid), 64'(0));
        chk("rst_res", 64'(result), 64'(0));
        chk("rst_flg", 64'(flags), 64'(0));
        nd = 1'b0;
        reset = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
            chk("rst_nd_ignored", 64'(valid), 64'(0));
        end

        run_op("sub3m1",   32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 3'b000);
        run_op("add3p1",   32'h40400000, 32'h3F800000, 1'b0, 32'h40800000, 3'b000);
        run_op("rne_tie",  32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 3'b000);
        run_op("rne_up",   32'h3F800000, 32'h33C00000, 1'b0, 32'h3F800001, 3'b000);
        run_op("rne_odd",  32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 3'b000);
        run_op("cancel",   32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 3'b000);
        run_op("inf_m_inf",32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 3'b100);
        run_op("inf_p_inf",32'h7F800000, 32'h7F800000, 1'b0, 32'h7F800000, 3'b000);
        run_op("nan_in",   32'h7FC01234, 32'h3F800000, 1'b0, 32'h7FC00000, 3'b000);
        run_op("one_m_inf",32'h3F800000, 32'h7F800000, 1'b1, 32'hFF800000, 3'b000);
        run_op("ovf",      32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 3'b010);
        run_op("ufl",      32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 3'b001);
        run_op("denorm_a", 32'h00000001, 32'h3F800000, 1'b0, 32'h3F800000, 3'b000);
        run_op("nz_p_nz",  32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 3'b000);
        run_op("nz_m_pz",  32'h80000000, 32'h00000000, 1'b1, 32'h80000000, 3'b000);
        run_op("z_m_one",  32'h00000000, 32'h3F800000, 1'b1, 32'hBF800000, 3'b000);
        run_op("sat_add",  32'h3F800000, 32'h30800000, 1'b0, 32'h3F800000, 3'b000);
        run_op("sat_sub",  32'h3F800000, 32'h30800000, 1'b1, 32'h3F800000, 3'b000);
        run_op("renorm",   32'h3F800000, 32'h33800000, 1'b1, 32'h3F7FFFFF, 3'b000);

        for (int k = 0; k < 3; k++) begin
            a = rand_normal(8'd0, 1'b0); b = rand_normal(8'd0, 1'b0); sub = k[0]; nd = 1'b1;
            @(posedge clk); #1;
        end
        nd = 1'b0;
        reset = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(valid), 64'(0));
        chk("mid_rst_res", 64'(result), 64'(0));
        chk("mid_rst_flg", 64'(flags), 64'(0));
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (6) begin
            @(posedge clk); #1;
            chk("mid_rst_drop", 64'(valid), 64'(0));
        end
        run_op("after_rst", 32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 3'b000);

        stream("stream16", 16);
        stream("stream_long", 400);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
